wb_byte_master: RTL
===================

// Module: wb_byte_master
// PURPOSE
//  Byte-serial-to-Wishbone initiator. It drives the USB device controller's Wishbone slave port
//  (14-bit ADR, 32-bit DAT, 4-bit SEL, classic single cycles) from an 8-bit command stream.
//  It returns status and read data as an 8-bit response stream.
//  It is the bus-master end used by the on-chip debug/loader path and the test harness.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max wait for wb_ACK, counted from the first STB-high cycle (only with WB_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock; all logic is rising-edge
//  rst          in   1   reset, asynchronous, active-high
//  cmd_data     in   8   command byte
//  cmd_valid    in   1   command byte present
//  cmd_ready    out  1   command byte accepted when cmd_valid&&cmd_ready
//  rsp_data     out  8   response byte
//  rsp_valid    out  1   response byte present
//  rsp_ready    in   1   response byte consumed when rsp_valid&&rsp_ready
//  wb_CYC       out  1   Wishbone cycle
//  wb_STB       out  1   Wishbone strobe
//  wb_WE        out  1   Wishbone write enable
//  wb_ADR       out  14  Wishbone address
//  wb_SEL       out  4   Wishbone byte selects
//  wb_DAT_MOSI  out  32  write data
//  wb_DAT_MISO  in   32  read data
//  wb_ACK       in   1   slave acknowledge
// BEHAVIOUR
//  Command frame, in byte order:
//   - HDR: [7]=WE, [3:0]=SEL, [6:4] ignored.
//   - ADR_HI: [5:0]=ADR[13:8], [7:6] ignored.
//   - ADR_LO: ADR[7:0].
//   - Write frames then carry 4 data bytes, LSB first.
//  Response frame:
//   - STATUS byte: 0x00=ACK, 0x01=timeout.
//   - Read frames then carry 4 data bytes, LSB first. The frame is always 5 bytes; data=0 on timeout.
//  FSM states: HDR -> AHI -> ALO -> (WE? WDAT x4) -> BUS -> RSTAT -> (!WE? RDAT x4) -> HDR.
//  cmd_ready:
//   - =1 in HDR/AHI/ALO/WDAT.
//   - =0 in BUS/RSTAT/RDAT.
//   - Each accepted byte advances one state/count.
//  BUS entry: CYC=STB=1 registered the cycle after the last command byte is accepted.
//   - WE/ADR/SEL/DAT_MOSI are stable for the whole cycle.
//  ACK handling:
//   - First cycle with wb_ACK=1 in BUS: capture wb_DAT_MISO and go to RSTAT.
//   - CYC/STB drop on the next edge; single-beat, no back-to-back.
//   - wb_ACK outside BUS is ignored.
//  Latency: last cmd byte -> STB is 1 clk; ACK -> rsp_valid is 1 clk.
//  Response handshake:
//   - rsp_valid=1 throughout RSTAT/RDAT.
//   - rsp_data is held stable while rsp_valid&&!rsp_ready.
//   - Each handshake advances the byte index (0..3, 2-bit, wraps to exit).
//  Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, CYC=STB=WE=0, ADR=0, SEL=0, DAT_MOSI=0.
//   - The FSM is in HDR after reset.
//   - Reset mid-frame or mid-bus-cycle abandons everything; CYC drops asynchronously.
//  The block sets no SEL=0 restriction: SEL is passed through as given.
// CONFIGURATION
//  WB_TIMEOUT_EN defined:
//   - A counter clears on BUS entry and increments each BUS cycle without ACK.
//   - At TIMEOUT_CYCLES it drops CYC/STB, sets status 0x01, and enters RSTAT.
//   - ACK in the same cycle as expiry wins (status 0x00).
//   - The counter width is $clog2(TIMEOUT_CYCLES+1).
//  WB_TIMEOUT_EN undefined:
//   - No counter; BUS waits indefinitely.
//   - Status is always 0x00 and TIMEOUT_CYCLES is unused.
// STRUCTURE
//  Package wb_byte_master_pkg holds:
//   - the state enum;
//   - STATUS_ACK=8'h00 and STATUS_TIMEOUT=8'h01;
//   - HDR field positions (HDR_WE_BIT=7, HDR_SEL_LSB=0);
//   - the ADR/DAT widths (14/32).
//  One sub-module, wb_byte_shreg: 32-bit byte-lane assembler/serialiser with 2-bit index.
//   - It is shared by the WDAT load and RDAT unload paths.
// TESTING
//  - Write: 0x8F,0x12,0x34,0xEF,0xBE,0xAD,0xDE, slave ACKs after 3 clks.
//    -> one cycle with ADR=0x1234, SEL=0xF, WE=1, DAT=0xDEADBEEF; response 0x00.
//  - Read: 0x03,0x00,0x10, slave returns 0xCAFEF00D.
//    -> ADR=0x0010, SEL=0x3, WE=0; response 0x00,0x0D,0xF0,0xFE,0xCA.
//  - Backpressure: rsp_ready toggling 1/0 every clk on the read above
//    -> identical byte sequence, no byte dropped or repeated, rsp_data stable while stalled.
//  - Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=4): read with no ACK
//    -> STB high exactly 4 clks; response 0x01,0,0,0,0.
//    -> Same with ACK on the 4th clk gives response 0x00.
//  - Reset mid-BUS: assert rst while CYC=1
//    -> CYC/STB=0 immediately, cmd_ready=1; the next full write frame completes normally.

Source files
------------

// File: rtl/wb_byte_master_pkg.sv
// Shared types and constants for the byte-serial Wishbone initiator.
// Holds the FSM state enum, status codes, header field positions and bus widths.
package wb_byte_master_pkg;

  localparam int ADR_W = 14;
  localparam int DAT_W = 32;

  localparam int HDR_WE_BIT  = 7;
  localparam int HDR_SEL_LSB = 0;

  localparam logic [7:0] STATUS_ACK     = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

  typedef enum logic [2:0] {
    S_HDR,
    S_AHI,
    S_ALO,
    S_WDAT,
    S_BUS,
    S_RSTAT,
    S_RDAT
  } state_t;

endpackage

// File: rtl/wb_byte_master_shreg.sv
// wb_byte_shreg: 32-bit byte-lane assembler/serialiser with a 2-bit lane index.
// Ports: clk, rst, wr (write byte_in to lane idx), load (take word_in, idx=0),
// adv (idx+1, wraps), word, byte_out (lane idx), idx.
import wb_byte_master_pkg::*;

module wb_byte_shreg (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [7:0]       byte_in,
  input  logic             load,
  input  logic [DAT_W-1:0] word_in,
  input  logic             adv,
  output logic [DAT_W-1:0] word,
  output logic [7:0]       byte_out,
  output logic [1:0]       idx
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= 2'd0;
    end else if (load) begin
      word <= word_in;
      idx  <= 2'd0;
    end else begin
      if (wr)
        word[{idx, 3'b000} +: 8] <= byte_in;
      if (adv)
        idx <= idx + 2'd1;
    end
  end

  assign byte_out = word[{idx, 3'b000} +: 8];

endmodule

// File: rtl/wb_byte_master.sv
// Byte-serial command stream to single-beat Wishbone initiator, 8-bit response stream.
// Ports: clk, rst (async, high), cmd_* in stream, rsp_* out stream, wb_* master port.
// Build option: define WB_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES.
import wb_byte_master_pkg::*;

module wb_byte_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             wb_CYC,
  output logic             wb_STB,
  output logic             wb_WE,
  output logic [ADR_W-1:0] wb_ADR,
  output logic [3:0]       wb_SEL,
  output logic [DAT_W-1:0] wb_DAT_MOSI,
  input  logic [DAT_W-1:0] wb_DAT_MISO,
  input  logic             wb_ACK
);

  state_t state, state_n;

  logic             we_q;
  logic [3:0]       sel_q;
  logic [ADR_W-1:0] adr_q;
  logic [7:0]       status_q;

  logic             cmd_fire;
  logic             tmo_hit;
  logic             bus_done;

  logic             sh_wr;
  logic             sh_load;
  logic             sh_adv;
  logic [DAT_W-1:0] sh_word_in;
  logic [DAT_W-1:0] sh_word;
  logic [7:0]       sh_byte;
  logic [1:0]       sh_idx;

  assign cmd_fire = cmd_valid && cmd_ready;

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Held at zero outside BUS, so it is clear on every BUS entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state != S_BUS)
      tmo_cnt <= '0;
    else if (!wb_ACK)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // An ACK in the expiry cycle takes priority.
  assign tmo_hit = (tmo_cnt == T_LAST) && !wb_ACK;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  assign bus_done = (state == S_BUS) && (wb_ACK || tmo_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_HDR;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_HDR:   if (cmd_fire) state_n = S_AHI;
      S_AHI:   if (cmd_fire) state_n = S_ALO;
      S_ALO:   if (cmd_fire) state_n = we_q ? S_WDAT : S_BUS;
      S_WDAT:  if (cmd_fire && sh_idx == 2'd3) state_n = S_BUS;
      S_BUS:   if (bus_done) state_n = S_RSTAT;
      S_RSTAT: if (rsp_ready) state_n = we_q ? S_HDR : S_RDAT;
      S_RDAT:  if (rsp_ready && sh_idx == 2'd3) state_n = S_HDR;
      default: state_n = S_HDR;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = 8'h00;
    sh_wr      = 1'b0;
    sh_adv     = 1'b0;
    sh_load    = 1'b0;
    sh_word_in = wb_ACK ? wb_DAT_MISO : '0;
    case (state)
      S_HDR, S_AHI, S_ALO: cmd_ready = 1'b1;
      S_WDAT: begin
        cmd_ready = 1'b1;
        sh_wr     = cmd_valid;
        sh_adv    = cmd_valid;
      end
      S_BUS:   sh_load = bus_done;
      S_RSTAT: begin
        rsp_valid = 1'b1;
        rsp_data  = status_q;
      end
      S_RDAT: begin
        rsp_valid = 1'b1;
        rsp_data  = sh_byte;
        sh_adv    = rsp_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      adr_q    <= '0;
      status_q <= STATUS_ACK;
    end else begin
      if (cmd_fire && state == S_HDR) begin
        we_q  <= cmd_data[HDR_WE_BIT];
        sel_q <= cmd_data[HDR_SEL_LSB +: 4];
      end
      if (cmd_fire && state == S_AHI)
        adr_q[ADR_W-1:8] <= cmd_data[ADR_W-9:0];
      if (cmd_fire && state == S_ALO)
        adr_q[7:0] <= cmd_data;
      if (bus_done)
        status_q <= wb_ACK ? STATUS_ACK : STATUS_TIMEOUT;
    end
  end

  wb_byte_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .wr       (sh_wr),
    .byte_in  (cmd_data),
    .load     (sh_load),
    .word_in  (sh_word_in),
    .adv      (sh_adv),
    .word     (sh_word),
    .byte_out (sh_byte),
    .idx      (sh_idx)
  );

  // Bus strobes come straight from the state register: one clock after
  // the last command byte, and cleared asynchronously by reset.
  assign wb_CYC      = (state == S_BUS);
  assign wb_STB      = (state == S_BUS);
  assign wb_WE       = we_q;
  assign wb_ADR      = adr_q;
  assign wb_SEL      = sel_q;
  assign wb_DAT_MOSI = sh_word;

endmodule
